// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect/halt handling.
// Optional FETCH_PERF_EN adds fetched/bubble/stall event counters.
module fetch_stage #(
  parameter int unsigned               AWIDTH    = 32,
  parameter int unsigned               DWIDTH    = 32,
  parameter logic [AWIDTH-1:0]         BASE_ADDR = AWIDTH'(32'h0100_0000),
  parameter logic [DWIDTH-1:0]         NOP_INSN  = DWIDTH'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic [DWIDTH-1:0] imem_data,
  output logic [AWIDTH-1:0] if_id_pc,
  output logic [DWIDTH-1:0] if_id_insn,
  output logic              if_id_valid,
  output logic              halted,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_stalls,
`endif
  output logic              misalign_err
);

  localparam logic [DWIDTH-1:0] ECALL_INSN = DWIDTH'(32'h0000_0073);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [DWIDTH-1:0] ifid_insn_q, ifid_insn_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              halted_q, halted_d;
  logic              misalign_q, misalign_d;
  logic              load_valid_c, load_bubble_c, stalled_c;
  logic              is_ecall_c;

  assign is_ecall_c = (imem_data == ECALL_INSN);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state: an unstalled, unredirected ecall fetch is the only way into HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (!redirect && !stall && is_ecall_c) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // Datapath next values and event strobes
  always_comb begin
    pc_d          = pc_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_insn_d   = ifid_insn_q;
    ifid_valid_d  = ifid_valid_q;
    halted_d      = halted_q;
    misalign_d    = misalign_q;
    load_valid_c  = 1'b0;
    load_bubble_c = 1'b0;
    stalled_c     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d          = {redirect_pc[AWIDTH-1:2], 2'b00};
          ifid_pc_d     = pc_q;
          ifid_insn_d   = NOP_INSN;
          ifid_valid_d  = 1'b0;
          load_bubble_c = 1'b1;
          if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (stall) begin
          stalled_c = 1'b1;
        end else begin
          pc_d         = pc_q + AWIDTH'(4);
          ifid_pc_d    = pc_q;
          ifid_insn_d  = imem_data;
          ifid_valid_d = 1'b1;
          load_valid_c = 1'b1;
          if (is_ecall_c) halted_d = 1'b1;
        end
      end
      default: begin
        // Halted: PC frozen, redirects dropped, bubbles flow on unstalled cycles
        if (stall) begin
          stalled_c = 1'b1;
        end else begin
          ifid_pc_d     = pc_q;
          ifid_insn_d   = NOP_INSN;
          ifid_valid_d  = 1'b0;
          load_bubble_c = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= BASE_ADDR;
      ifid_pc_q    <= BASE_ADDR;
      ifid_insn_q  <= NOP_INSN;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_insn_q  <= ifid_insn_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_id_pc     = ifid_pc_q;
  assign if_id_insn   = ifid_insn_q;
  assign if_id_valid  = ifid_valid_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q, perf_stalls_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
      perf_stalls_q  <= 32'd0;
    end else begin
      if (load_valid_c)  perf_fetched_q <= perf_fetched_q + 32'd1;
      if (load_bubble_c) perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (stalled_c)     perf_stalls_q  <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
  assign perf_stalls  = perf_stalls_q;
`else
  logic unused_perf_c;
  assign unused_perf_c = load_valid_c ^ load_bubble_c ^ stalled_c;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; perf counters checked when FETCH_PERF_EN is defined.
module tb_fetch_stage;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_data;
  logic [31:0] if_id_pc, if_id_insn;
  logic        if_id_valid, halted, misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_stalls;
`endif

  logic [31:0] mem [0:63];
  logic [31:0] off;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_id_pc     (if_id_pc),
    .if_id_insn   (if_id_insn),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
`ifdef FETCH_PERF_EN
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles),
    .perf_stalls  (perf_stalls),
`endif
    .misalign_err (misalign_err)
  );

  // Combinational instruction memory around BASE; NOP elsewhere
  always_comb begin
    off = imem_addr - BASE;
    if (off < 32'd256) imem_data = mem[off[7:2]];
    else               imem_data = NOP;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h00a0_0113;
    mem[2]  = 32'h0020_81b3;
    mem[3]  = 32'h0030_8233;
    mem[16] = 32'h0010_0293;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);

    // Reset state
    do_reset();
    check("rst_pc", imem_addr, BASE);
    check("rst_ifid_pc", if_id_pc, BASE);
    check("rst_insn", if_id_insn, NOP);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    // Three free-running fetches
    step();
    check("f0_pc", if_id_pc, BASE);
    check("f0_insn", if_id_insn, 32'h0050_0093);
    check("f0_valid", 32'(if_id_valid), 32'd1);
    step();
    check("f1_pc", if_id_pc, BASE + 32'h4);
    check("f1_insn", if_id_insn, 32'h00a0_0113);
    step();
    check("f2_pc", if_id_pc, BASE + 32'h8);
    check("f2_insn", if_id_insn, 32'h0020_81b3);
    check("f2_valid", 32'(if_id_valid), 32'd1);
    check("f2_nextpc", imem_addr, BASE + 32'hc);

    // Two-cycle stall at pc=BASE+8
    do_reset();
    step();
    step();
    check("pre_stall_pc", imem_addr, BASE + 32'h8);
    drive(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_pc", imem_addr, BASE + 32'h8);
      check("stall_ifid_pc", if_id_pc, BASE + 32'h4);
      check("stall_insn", if_id_insn, 32'h00a0_0113);
      check("stall_valid", 32'(if_id_valid), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("rel_ifid_pc", if_id_pc, BASE + 32'h8);
    check("rel_insn", if_id_insn, 32'h0020_81b3);
    check("rel_pc", imem_addr, BASE + 32'hc);

    // Redirect beats a simultaneous stall
    drive(1'b1, 1'b1, BASE + 32'h40);
    step();
    check("rd_pc", imem_addr, BASE + 32'h40);
    check("rd_insn", if_id_insn, NOP);
    check("rd_valid", 32'(if_id_valid), 32'd0);
    check("rd_ifid_pc", if_id_pc, BASE + 32'hc);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("rd_tgt_pc", if_id_pc, BASE + 32'h40);
    check("rd_tgt_insn", if_id_insn, 32'h0010_0293);
    check("rd_tgt_valid", 32'(if_id_valid), 32'd1);
    check("rd_misalign", 32'(misalign_err), 32'd0);

    // Misaligned redirect target
    drive(1'b0, 1'b1, BASE + 32'h42);
    step();
    check("mis_pc", imem_addr, BASE + 32'h40);
    check("mis_err", 32'(misalign_err), 32'd1);
    drive(1'b0, 1'b0, 32'h0);
    step();
    step();
    check("mis_sticky", 32'(misalign_err), 32'd1);

    // Ecall halt
    mem[4] = ECALL;
    drive(1'b0, 1'b1, BASE + 32'h10);
    step();
    check("h_redirect_pc", imem_addr, BASE + 32'h10);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("h_halted", 32'(halted), 32'd1);
    check("h_pc", imem_addr, BASE + 32'h14);
    check("h_insn", if_id_insn, ECALL);
    drive(1'b1, 1'b0, 32'h0);
    step();
    check("h_stall_insn", if_id_insn, ECALL);
    check("h_stall_pc", imem_addr, BASE + 32'h14);
    drive(1'b0, 1'b1, BASE + 32'h80);
    step();
    check("h_rd_ign_pc", imem_addr, BASE + 32'h14);
    check("h_bubble_insn", if_id_insn, NOP);
    check("h_bubble_valid", 32'(if_id_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("h_bubble2_insn", if_id_insn, NOP);
    check("h_halted_hold", 32'(halted), 32'd1);
    check("h_misalign_hold", 32'(misalign_err), 32'd1);
    do_reset();
    check("h_rst_pc", imem_addr, BASE);
    check("h_rst_halted", 32'(halted), 32'd0);
    check("h_rst_misalign", 32'(misalign_err), 32'd0);
    mem[4] = NOP;

    // PC wraps at the top of the address space
    drive(1'b0, 1'b1, 32'hffff_fffc);
    step();
    check("wrap_top", imem_addr, 32'hffff_fffc);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("wrap_pc", imem_addr, 32'h0000_0000);
    check("wrap_ifid_pc", if_id_pc, 32'hffff_fffc);
    check("wrap_valid", 32'(if_id_valid), 32'd1);

`ifdef FETCH_PERF_EN
    // 5 fetches, 1 redirect, 2 stalls
    do_reset();
    check("perf_rst_fetched", perf_fetched, 32'd0);
    for (int k = 0; k < 3; k++) step();
    drive(1'b1, 1'b0, 32'h0);
    step();
    step();
    drive(1'b0, 1'b1, BASE + 32'h40);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    step();
    check("perf_fetched", perf_fetched, 32'd5);
    check("perf_bubbles", perf_bubbles, 32'd1);
    check("perf_stalls", perf_stalls, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
